dcache_ctrl: RTL and testbench

//  Direct-mapped, write-back, write-allocate L1 data cache between the pipeline MEM stage and off-chip data memory.

---
 rtl/dcache_ctrl.sv | 104 ++++++++++
 tb/tb_dcache_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped, write-back, write-allocate L1 data cache controller
// Hits complete in the same cycle; a miss stalls the pipeline while whole lines move over a req/ack bus.
module dcache_ctrl #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LINE_W = 256,
    parameter int SETS   = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_i,
    input  logic              wr_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic              stall_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [LINE_W-1:0] mem_wdata_o,
    input  logic [LINE_W-1:0] mem_rdata_i,
    input  logic              mem_ack_i
);
    localparam int OFF_W  = $clog2(LINE_W / 8);
    localparam int IDX_W  = $clog2(SETS);
    localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
    localparam int WSEL_W = $clog2(LINE_W / DATA_W);
    localparam int BOFF_W = $clog2(DATA_W);

    typedef enum logic [2:0] {IDLE, WRITEBACK, WB_GAP, ALLOCATE, REFILL} state_t;

    state_t                    state, state_nxt;
    logic [SETS-1:0]           valid, dirty;
    logic [TAG_W-1:0]          tag_mem [SETS];
    logic [LINE_W-1:0]         data_mem [SETS];
    logic [LINE_W-1:0]         fill_buf;
    logic [ADDR_W-OFF_W-1:0]   miss_line;
    logic [DATA_W-1:0]         rdata_q;
    logic [IDX_W-1:0]          idx, miss_idx;
    logic [TAG_W-1:0]          tag;
    logic [WSEL_W-1:0]         wsel;
    logic [$clog2(LINE_W)-1:0] wbit;
    logic                      hit, rd_hit, wr_hit, unused_bits;

    assign idx         = addr_i[OFF_W +: IDX_W];
    assign tag         = addr_i[ADDR_W-1 -: TAG_W];
    assign wsel        = addr_i[OFF_W-1 -: WSEL_W];
    assign wbit        = {wsel, {BOFF_W{1'b0}}};
    assign miss_idx    = miss_line[IDX_W-1:0];
    assign unused_bits = ^addr_i[OFF_W-WSEL_W-1:0];
    assign hit         = (state == IDLE) && valid[idx] && (tag_mem[idx] == tag);
    assign rd_hit      = req_i && hit && !wr_i;
    assign wr_hit      = req_i && hit && wr_i;

    always_ff @(posedge clk_i)
        if (rst_i) state <= IDLE;
        else state <= state_nxt;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (req_i && !hit) state_nxt = (valid[idx] && dirty[idx]) ? WRITEBACK : ALLOCATE;
            WRITEBACK: if (mem_ack_i) state_nxt = WB_GAP;
            WB_GAP:    state_nxt = ALLOCATE;
            ALLOCATE:  if (mem_ack_i) state_nxt = REFILL;
            default:   state_nxt = IDLE;
        endcase
    end

    // Bus fields come from the latched miss address so they stay put even if the CPU drops req_i.
    always_comb begin
        mem_req_o   = (state == WRITEBACK) || (state == ALLOCATE);
        mem_we_o    = state == WRITEBACK;
        mem_addr_o  = (state == WRITEBACK) ? {tag_mem[miss_idx], miss_idx, {OFF_W{1'b0}}} :
                      (state == ALLOCATE)  ? {miss_line, {OFF_W{1'b0}}} : '0;
        mem_wdata_o = (state == WRITEBACK) ? data_mem[miss_idx] : '0;
        stall_o     = (state != IDLE) || (req_i && !hit);
        rdata_o     = rd_hit ? data_mem[idx][wbit +: DATA_W] : rdata_q;
    end

    always_ff @(posedge clk_i)
        if (rst_i) begin
            valid   <= '0;
            dirty   <= '0;
            rdata_q <= '0;
        end else begin
            if (rd_hit) rdata_q <= data_mem[idx][wbit +: DATA_W];
            if (wr_hit) dirty[idx] <= 1'b1;
            if (state == REFILL) begin
                valid[miss_idx] <= 1'b1;
                dirty[miss_idx] <= 1'b0;
            end
        end

    always_ff @(posedge clk_i) begin
        if (state == IDLE && req_i && !hit) miss_line <= addr_i[ADDR_W-1:OFF_W];
        if (state == ALLOCATE && mem_ack_i) fill_buf <= mem_rdata_i;
        if (!rst_i && wr_hit) data_mem[idx][wbit +: DATA_W] <= wdata_i;
        if (!rst_i && state == REFILL) begin
            data_mem[miss_idx] <= fill_buf;
            tag_mem[miss_idx]  <= miss_line[ADDR_W-OFF_W-1 -: TAG_W];
        end
    end
endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl: directed bench with a functional cache/memory model checked every cycle
module tb_dcache_ctrl;
    logic         clk = 0, rst_i, req_i, wr_i, stall_o, mem_req_o, mem_we_o, mem_ack_i;
    logic [31:0]  addr_i, wdata_i, rdata_o, mem_addr_o;
    logic [255:0] mem_wdata_o, mem_rdata_i;

    dcache_ctrl dut (
        .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .wr_i(wr_i), .addr_i(addr_i),
        .wdata_i(wdata_i), .rdata_o(rdata_o), .stall_o(stall_o), .mem_req_o(mem_req_o),
        .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i)
    );

    always #5 clk = ~clk;

    typedef struct {logic we; logic [31:0] addr; logic [255:0] data;} txn_t;

    int           errors = 0, checks = 0, ack_lat = 3;
    bit           ack_pulse = 0;
    logic [255:0] mem_img [logic [26:0]];
    logic [31:0]  m_valid, m_dirty;
    logic [21:0]  m_tag [32];
    logic [255:0] m_line [32];
    logic [31:0]  last_wb_addr, last_fetch_addr;
    logic [255:0] last_wb_data;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Backing memory: untouched lines hold 0x5A5A0000 | byte address in every word.
    function automatic logic [255:0] line_of(input logic [31:0] a);
        logic [255:0] l;
        if (mem_img.exists(a[31:5])) return mem_img[a[31:5]];
        for (int k = 0; k < 8; k++) l[32*k +: 32] = 32'h5A5A_0000 | {a[31:5], 5'b0} | 32'(4 * k);
        return l;
    endfunction

    // Memory responder plus cycle-by-cycle comparison against the functional model.
    initial begin
        txn_t        q[$];
        txn_t        t;
        bit          active = 0, acking = 0, after_ack = 0, in_miss = 0, hit;
        int          rcnt = 0, mcnt = 0, ncnt = 0, scnt = 0, w;
        logic [4:0]  ix;
        logic [31:0] last_rd = '0, word;
        mem_ack_i   = 0;
        mem_rdata_i = '0;
        forever begin
            @(negedge clk);
            if (rst_i) begin
                m_valid = '0; m_dirty = '0; q.delete();
                active = 0; acking = 0; after_ack = 0; in_miss = 0;
                last_rd = '0; mem_ack_i = 0; ack_pulse = 0;
            end else begin
                if (acking) begin
                    t = q.pop_front();
                    acking = 0; active = 0; after_ack = 1;
                    if (t.we) mem_img[t.addr[31:5]] = t.data;
                    else m_line[t.addr[9:5]] = line_of(t.addr);
                end
                mem_ack_i = 0;
                if (after_ack) begin
                    chk("req_gap", {255'b0, mem_req_o}, 256'd0);
                    after_ack = 0;
                end else if (mem_req_o) begin
                    if (!active && q.size() == 0) chk("unexpected_req", {255'b0, mem_req_o}, 256'd0);
                    else begin
                        if (!active) begin
                            active = 1; rcnt = 0;
                            if (q[0].we) begin last_wb_addr = mem_addr_o; last_wb_data = mem_wdata_o; end
                            else last_fetch_addr = mem_addr_o;
                        end
                        chk("mem_we", {255'b0, mem_we_o}, {255'b0, q[0].we});
                        chk("mem_addr", {224'b0, mem_addr_o}, {224'b0, q[0].addr});
                        if (q[0].we) chk("mem_wdata", mem_wdata_o, q[0].data);
                        rcnt++;
                        if (q[0].we) mcnt++; else ncnt++;
                        if (rcnt == ack_lat) begin
                            mem_ack_i = 1; mem_rdata_i = line_of(q[0].addr); acking = 1;
                        end
                    end
                end else if (active) chk("req_dropped", {255'b0, mem_req_o}, 256'd1);
                if (ack_pulse) begin mem_ack_i = 1; ack_pulse = 0; end
                if (in_miss) begin
                    if (stall_o) scnt++;
                    else begin
                        chk("stall_len", 256'(scnt), 256'(mcnt > 0 ? 3 + mcnt + ncnt : 2 + ncnt));
                        in_miss = 0;
                    end
                end
                if (!in_miss) begin
                    ix = addr_i[9:5];
                    w  = int'(addr_i[4:2]);
                    if (req_i) begin
                        hit = m_valid[ix] && m_tag[ix] == addr_i[31:10];
                        chk("stall", {255'b0, stall_o}, {255'b0, !hit});
                        if (!hit) begin
                            if (m_valid[ix] && m_dirty[ix]) q.push_back('{1'b1, {m_tag[ix], ix, 5'b0}, m_line[ix]});
                            q.push_back('{1'b0, {addr_i[31:5], 5'b0}, '0});
                            m_valid[ix] = 1; m_dirty[ix] = 0; m_tag[ix] = addr_i[31:10];
                            in_miss = 1; scnt = 1; mcnt = 0; ncnt = 0;
                        end else if (wr_i) begin
                            m_line[ix][32*w +: 32] = wdata_i;
                            m_dirty[ix] = 1;
                        end else begin
                            word = m_line[ix][32*w +: 32];
                            chk("rdata", {224'b0, rdata_o}, {224'b0, word});
                            last_rd = word;
                        end
                    end else begin
                        chk("stall_idle", {255'b0, stall_o}, 256'd0);
                        chk("rdata_hold", {224'b0, rdata_o}, {224'b0, last_rd});
                    end
                end
            end
        end
    end

    task automatic access(input logic [31:0] a, input logic w, input logic [31:0] d, output int nst);
        @(posedge clk); #1;
        req_i = 1; wr_i = w; addr_i = a; wdata_i = d; nst = 0;
        do begin
            @(negedge clk);
            if (stall_o) nst++;
        end while (stall_o && nst < 200);
        if (stall_o) chk("access_timeout", {255'b0, stall_o}, 256'd0);
    endtask

    task automatic wait_req();
        int i = 0;
        do begin @(negedge clk); i++; end while (!mem_req_o && i < 100);
        if (!mem_req_o) chk("req_timeout", {255'b0, mem_req_o}, 256'd1);
    endtask

    initial begin
        int n, i;
        logic [31:0] a;
        rst_i = 1; req_i = 0; wr_i = 0; addr_i = '0; wdata_i = '0;
        repeat (3) @(posedge clk);
        #1 rst_i = 0;
        @(negedge clk);
        chk("rst_stall", {255'b0, stall_o}, 256'd0);
        chk("rst_mem_req", {255'b0, mem_req_o}, 256'd0);
        chk("rst_mem_we", {255'b0, mem_we_o}, 256'd0);
        chk("rst_mem_addr", {224'b0, mem_addr_o}, 256'd0);
        chk("rst_mem_wdata", mem_wdata_o, 256'd0);
        chk("rst_rdata", {224'b0, rdata_o}, 256'd0);

        access(32'h40, 0, 0, n);
        chk("t1_stall", 256'(n), 256'd5);
        chk("t1_rdata", {224'b0, rdata_o}, 256'h5A5A0040);
        chk("t1_fetch_addr", {224'b0, last_fetch_addr}, 256'h40);

        access(32'h44, 1, 32'hDEADBEEF, n);
        chk("t2_store_stall", 256'(n), 256'd0);
        access(32'h44, 0, 0, n);
        chk("t2_load_stall", 256'(n), 256'd0);
        chk("t2_rdata", {224'b0, rdata_o}, 256'hDEADBEEF);

        access(32'h440, 0, 0, n);
        chk("t3_stall", 256'(n), 256'd9);
        chk("t3_wb_addr", {224'b0, last_wb_addr}, 256'h40);
        chk("t3_wb_word1", {224'b0, last_wb_data[63:32]}, 256'hDEADBEEF);
        chk("t3_fetch_addr", {224'b0, last_fetch_addr}, 256'h440);
        chk("t3_rdata", {224'b0, rdata_o}, 256'h5A5A0440);

        @(posedge clk); #1;
        req_i = 1; wr_i = 0; addr_i = 32'h40;
        wait_req();
        @(posedge clk); #1 rst_i = 1; req_i = 0;
        @(posedge clk); #1 rst_i = 0;
        @(negedge clk);
        chk("t4_mem_req", {255'b0, mem_req_o}, 256'd0);
        chk("t4_stall", {255'b0, stall_o}, 256'd0);
        access(32'h440, 0, 0, n);
        chk("t4_reload_stall", 256'(n), 256'd5);
        chk("t4_rdata", {224'b0, rdata_o}, 256'h5A5A0440);

        @(posedge clk); #1 req_i = 0; ack_pulse = 1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("t5_idle_ack_stall", {255'b0, stall_o}, 256'd0);
        chk("t5_idle_ack_req", {255'b0, mem_req_o}, 256'd0);
        access(32'h440, 0, 0, n);
        chk("t5_hit_after_ack", 256'(n), 256'd0);
        @(posedge clk); #1;
        req_i = 1; wr_i = 0; addr_i = 32'h840;
        wait_req();
        @(posedge clk); #1 req_i = 0;
        i = 0;
        do begin @(negedge clk); i++; end while (stall_o && i < 100);
        chk("t5_fill_done", {255'b0, stall_o}, 256'd0);
        chk("t5_fill_req", {255'b0, mem_req_o}, 256'd0);
        access(32'h840, 0, 0, n);
        chk("t5_hit_stall", 256'(n), 256'd0);
        chk("t5_rdata", {224'b0, rdata_o}, 256'h5A5A0840);

        access(32'h40, 0, 0, n);
        chk("t6_fill_stall", 256'(n), 256'd5);
        for (int k = 0; k < 8; k++) begin
            a = 32'h40 + 32'(4 * k);
            access(a, 0, 0, n);
            chk("t6_stall", 256'(n), 256'd0);
            chk("t6_rdata", {224'b0, rdata_o}, {224'b0, (a == 32'h44) ? 32'hDEADBEEF : (32'h5A5A_0000 | a)});
        end

        ack_lat = 1;
        access(32'h104, 1, 32'h12345678, n);
        chk("sm_stall", 256'(n), 256'd3);
        access(32'h104, 0, 0, n);
        chk("sm_rdata", {224'b0, rdata_o}, 256'h12345678);
        access(32'h904, 0, 0, n);
        chk("sm_dirty_stall", 256'(n), 256'd5);
        chk("sm_wb_addr", {224'b0, last_wb_addr}, 256'h100);
        access(32'h104, 0, 0, n);
        chk("sm_reload_stall", 256'(n), 256'd3);
        chk("sm_reload_rdata", {224'b0, rdata_o}, 256'h12345678);

        @(posedge clk); #1 req_i = 0;
        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
